// File: rtl/interp_fp_pkg.sv
// Shared widths and operand/result records for the interpolator floating-point datapath.
package interp_fp_pkg;

  localparam int EXP_W = 8;
  localparam int SIG_W = 12;

  localparam logic [SIG_W-1:0] SIG_ONE = {1'b1, {(SIG_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_operand_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             zero;
    logic             ovf;
  } fp_sum_t;

endpackage

// File: rtl/fp_align_shifter.sv
// Truncating right shift of the smaller significand; shifts of SIG_W or more yield zero.
module fp_align_shifter
  import interp_fp_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  input  logic [EXP_W-1:0] diff,
  output logic [SIG_W-1:0] aligned
);

  // barrel shift with saturation to zero
  always_comb begin
    if (diff >= EXP_W'(SIG_W)) begin
      aligned = {SIG_W{1'b0}};
    end else begin
      aligned = sig >> diff;
    end
  end

endmodule

// File: rtl/fp_align_add.sv
// Three-stage compare/swap, align and add/subtract of two significands with a
// valid/ready handshake; raw result feeds the normalisation stage.
module fp_align_add
  import interp_fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             a_sign,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [SIG_W-1:0] a_sig,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [SIG_W-1:0] b_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_zero,
  output logic             out_ovf
);

  logic             s1_valid_r, s2_valid_r, s3_valid_r;
  logic             ld1_s, ld2_s, ld3_s;

  fp_operand_t      a_op_s, b_op_s, l_op_s, s_op_s;
  logic             swap_s;

  fp_operand_t      s1_l_r;
  logic [SIG_W-1:0] s1_s_sig_r;
  logic [EXP_W-1:0] s1_diff_r;
  logic             s1_eff_sub_r;

  logic [SIG_W-1:0] aligned_s;
  fp_operand_t      s2_l_r;
  logic [SIG_W-1:0] s2_aligned_r;
  logic             s2_eff_sub_r;

  logic [SIG_W:0]   sum_s;
  fp_sum_t          res_s;
  fp_sum_t          s3_res_r;

  // a stage loads when empty or when the stage after it is loading
  assign ld3_s    = !s3_valid_r || out_ready;
  assign ld2_s    = !s2_valid_r || ld3_s;
  assign ld1_s    = !s1_valid_r || ld2_s;
  assign in_ready = ld1_s;

  // order operands by magnitude so the exponent difference is never negative
  always_comb begin
    a_op_s = '{sign: a_sign, exp: a_exp, sig: a_sig};
    b_op_s = '{sign: b_sign ^ op_sub, exp: b_exp, sig: b_sig};
    swap_s = {b_exp, b_sig} > {a_exp, a_sig};
    if (swap_s) begin
      l_op_s = b_op_s;
      s_op_s = a_op_s;
    end else begin
      l_op_s = a_op_s;
      s_op_s = b_op_s;
    end
  end

  // stage 1 register: larger operand, smaller significand, shift distance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_l_r       <= '0;
      s1_s_sig_r   <= {SIG_W{1'b0}};
      s1_diff_r    <= {EXP_W{1'b0}};
      s1_eff_sub_r <= 1'b0;
    end else if (ld1_s) begin
      s1_valid_r   <= in_valid;
      s1_l_r       <= l_op_s;
      s1_s_sig_r   <= s_op_s.sig;
      s1_diff_r    <= l_op_s.exp - s_op_s.exp;
      s1_eff_sub_r <= l_op_s.sign ^ s_op_s.sign;
    end
  end

  fp_align_shifter u_shifter (
    .sig     (s1_s_sig_r),
    .diff    (s1_diff_r),
    .aligned (aligned_s)
  );

  // stage 2 register: aligned smaller significand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r   <= 1'b0;
      s2_l_r       <= '0;
      s2_aligned_r <= {SIG_W{1'b0}};
      s2_eff_sub_r <= 1'b0;
    end else if (ld2_s) begin
      s2_valid_r   <= s1_valid_r;
      s2_l_r       <= s1_l_r;
      s2_aligned_r <= aligned_s;
      s2_eff_sub_r <= s1_eff_sub_r;
    end
  end

  // effective add/sub with carry renormalisation, saturation and zero detect
  always_comb begin
    res_s = '0;
    if (s2_eff_sub_r) begin
      sum_s = {1'b0, s2_l_r.sig} - {1'b0, s2_aligned_r};
      if (sum_s[SIG_W-1:0] == {SIG_W{1'b0}}) begin
        res_s.zero = 1'b1;
      end else begin
        res_s.sign = s2_l_r.sign;
        res_s.exp  = s2_l_r.exp;
        res_s.sig  = sum_s[SIG_W-1:0];
      end
    end else begin
      sum_s      = {1'b0, s2_l_r.sig} + {1'b0, s2_aligned_r};
      res_s.sign = s2_l_r.sign;
      if (!sum_s[SIG_W]) begin
        res_s.exp = s2_l_r.exp;
        res_s.sig = sum_s[SIG_W-1:0];
      end else if (s2_l_r.exp == {EXP_W{1'b1}}) begin
        res_s.exp = {EXP_W{1'b1}};
        res_s.sig = {SIG_W{1'b1}};
        res_s.ovf = 1'b1;
      end else begin
        res_s.exp = s2_l_r.exp + {{(EXP_W-1){1'b0}}, 1'b1};
        res_s.sig = sum_s[SIG_W:1];
      end
    end
  end

  // stage 3 register drives the outputs directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_r <= 1'b0;
      s3_res_r   <= '0;
    end else if (ld3_s) begin
      s3_valid_r <= s2_valid_r;
      s3_res_r   <= res_s;
    end
  end

  assign out_valid = s3_valid_r;
  assign out_sign  = s3_res_r.sign;
  assign out_exp   = s3_res_r.exp;
  assign out_sig   = s3_res_r.sig;
  assign out_zero  = s3_res_r.zero;
  assign out_ovf   = s3_res_r.ovf;

endmodule

// File: tb/tb_fp_align_add.sv
// Randomised bench for fp_align_add: arithmetic reference model, in-order scoreboard,
// handshake/latency/stability checks, directed corner vectors and mid-stream reset.
module tb_fp_align_add;
  import interp_fp_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             op_sub = 1'b0;
  logic             a_sign = 1'b0, b_sign = 1'b0;
  logic [EXP_W-1:0] a_exp = '0, b_exp = '0;
  logic [SIG_W-1:0] a_sig = '0, b_sig = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [SIG_W-1:0] out_sig;
  logic             out_zero;
  logic             out_ovf;

  fp_align_add dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a_sign(a_sign), .a_exp(a_exp), .a_sig(a_sig),
    .b_sign(b_sign), .b_exp(b_exp), .b_sig(b_sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_sig(out_sig), .out_zero(out_zero), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt = 0;
  logic rand_rdy_en = 1'b0;

  fp_sum_t exp_q[$];
  int      acc_cyc_q[$];
  int      acc_stall_q[$];
  logic    hold_prev = 1'b0;
  fp_sum_t held;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic fp_sum_t mk(input int s, input int e, input int g, input int z, input int o);
    fp_sum_t r;
    r.sign = s[0]; r.exp = e[7:0]; r.sig = g[11:0]; r.zero = z[0]; r.ovf = o[0];
    return r;
  endfunction

  // Reference model: plain integer arithmetic on magnitudes.
  function automatic fp_sum_t model(input int sub, input int as, input int ae, input int ag,
                                    input int bs, input int be, input int bg);
    int bse, ls, le, lg, ss, se, sg, d, al, sum, r;
    bse = bs ^ sub;
    if (be * 4096 + bg > ae * 4096 + ag) begin
      ls = bse; le = be; lg = bg; ss = as; se = ae; sg = ag;
    end else begin
      ls = as; le = ae; lg = ag; ss = bse; se = be; sg = bg;
    end
    d  = le - se;
    al = (d >= 12) ? 0 : sg / (2 ** d);
    if (ls == ss) begin
      sum = lg + al;
      if (sum >= 4096) begin
        if (le == 255) return mk(ls, 255, 4095, 0, 1);
        return mk(ls, le + 1, sum / 2, 0, 0);
      end
      return mk(ls, le, sum, 0, 0);
    end
    r = ((lg - al) % 4096 + 4096) % 4096;
    if (r == 0) return mk(0, 0, 0, 1, 0);
    return mk(ls, le, r, 0, 0);
  endfunction

  // Monitor: handshake, stability, scoreboard and latency, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      cyc++;
      chk("in_ready", {63'd0, in_ready}, {63'd0, (exp_q.size() < 3) || out_ready});
      if (hold_prev) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_data", {41'd0, out_sign, out_exp, out_sig, out_zero, out_ovf}, {41'd0, held});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          fp_sum_t e;
          int ac, as_;
          e = exp_q.pop_front(); ac = acc_cyc_q.pop_front(); as_ = acc_stall_q.pop_front();
          chk("result", {41'd0, out_sign, out_exp, out_sig, out_zero, out_ovf}, {41'd0, e});
          if (as_ == stall_cnt) chk("latency", 64'(cyc - ac), 64'd3);
        end
      end else if (out_valid) begin
        stall_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op_sub, a_sign, a_exp, a_sig, b_sign, b_exp, b_sig));
        acc_cyc_q.push_back(cyc);
        acc_stall_q.push_back(stall_cnt);
      end
      hold_prev = out_valid && !out_ready;
      held = '{sign: out_sign, exp: out_exp, sig: out_sig, zero: out_zero, ovf: out_ovf};
    end
  end

  // Random downstream readiness when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int sub, input fp_operand_t a, input fp_operand_t b);
    int w;
    logic ok;
    op_sub = sub[0];
    a_sign = a.sign; a_exp = a.exp; a_sig = a.sig;
    b_sign = b.sign; b_exp = b.exp; b_sig = b.sig;
    in_valid = 1'b1;
    ok = 1'b0; w = 0;
    while (!ok && w < 200) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; w++;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk); w++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic fp_operand_t op(input int s, input int e, input int g);
    fp_operand_t r;
    r.sign = s[0]; r.exp = e[7:0]; r.sig = g[11:0];
    return r;
  endfunction

  function automatic fp_operand_t rand_op();
    return op($urandom_range(0, 1), $urandom_range(0, 255), 2048 + $urandom_range(0, 2047));
  endfunction

  task automatic send_random();
    fp_operand_t a, b;
    int e, k;
    a = rand_op(); b = rand_op();
    k = $urandom_range(0, 15);
    if (k == 0) begin
      a.exp = 8'hFF; b.exp = 8'hFF;
    end else if (k == 1) begin
      b = a;
    end else if (k < 12) begin
      e = int'(a.exp) + $urandom_range(0, 6) - 3;
      if (e < 0) e = 0;
      if (e > 255) e = 255;
      b.exp = e[7:0];
    end
    send($urandom_range(0, 1), a, b);
  endtask

  initial begin
    // model pinned to hand-computed values
    chk("pin_carry", 64'(model(0, 0, 'h80, 'h800, 0, 'h80, 'h800)), 64'(mk(0, 'h81, 'h800, 0, 0)));
    chk("pin_align", 64'(model(0, 0, 'h82, 'hC00, 0, 'h80, 'h800)), 64'(mk(0, 'h82, 'hE00, 0, 0)));
    chk("pin_swap", 64'(model(1, 0, 'h80, 'h800, 0, 'h80, 'hC00)), 64'(mk(1, 'h80, 'h400, 0, 0)));
    chk("pin_zero", 64'(model(1, 0, 'h80, 'h800, 0, 'h80, 'h800)), 64'(mk(0, 0, 0, 1, 0)));
    chk("pin_shout", 64'(model(0, 0, 'h90, 'hA00, 0, 'h80, 'hFFF)), 64'(mk(0, 'h90, 'hA00, 0, 0)));
    chk("pin_ovf", 64'(model(0, 0, 'hFF, 'hFFF, 0, 'hFF, 'hFFF)), 64'(mk(0, 'hFF, 'hFFF, 0, 1)));

    // reset state
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {41'd0, out_sign, out_exp, out_sig, out_zero, out_ovf}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors, back to back
    send(0, op(0, 'h80, 'h800), op(0, 'h80, 'h800));
    send(0, op(0, 'h82, 'hC00), op(0, 'h80, 'h800));
    send(1, op(0, 'h80, 'h800), op(0, 'h80, 'hC00));
    send(1, op(0, 'h80, 'h800), op(0, 'h80, 'h800));
    send(0, op(0, 'h90, 'hA00), op(0, 'h80, 'hFFF));
    send(0, op(0, 'hFF, 'hFFF), op(0, 'hFF, 'hFFF));
    send(1, op(1, 'h40, 'h801), op(0, 'h00, 'hFFF));
    drain();

    // backpressure: six back-to-back pairs, out_ready low for cycles 2-8
    fork
      begin
        for (int i = 0; i < 6; i++) send_random();
      end
      begin
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with data in flight
    for (int i = 0; i < 3; i++) send_random();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_data", {41'd0, out_sign, out_exp, out_sig, out_zero, out_ovf}, 64'd0);
    exp_q.delete(); acc_cyc_q.delete(); acc_stall_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_valid", {63'd0, out_valid}, 64'd0);

    // random traffic with random backpressure
    rand_rdy_en = 1'b1;
    for (int i = 0; i < 400; i++) send_random();
    rand_rdy_en = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
